// File: rtl/imem_pkg.sv
// Shared types for the instruction fetch path: fetch entry record and PC-to-word helper.
// No logic; no latency; no flow control.
// Imported by the fetch controller and its skid buffer.
package imem_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Byte PC to word index; callers truncate to their memory address width.
    function automatic logic [XLEN-1:0] pc_to_waddr(input logic [XLEN-1:0] pc);
        return {2'b00, pc[XLEN-1:2]};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry skid buffer of {pc, instr} fetch responses with flush on redirect.
// Latency: one cycle from push to head; flush empties it at the next edge.
// No internal backpressure: the controller's credit check keeps it from overflowing.
module fetch_skid_buf
    import imem_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   occ_o,
    output fetch_entry_t head_o
);

    logic [$bits(fetch_entry_t)-1:0] head_raw;

    fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_i),
        .din_i   (entry_i),
        .pop_i   (pop_i),
        .flush_i (flush_i),
        .occ_o   (occ_o),
        .head_o  (head_raw)
    );

    assign head_o = fetch_entry_t'(head_raw);

endmodule

// File: rtl/fifo.sv
// Generic small FIFO with synchronous flush; head is visible combinationally.
// Latency: a push is visible at head the cycle after it is written.
// No internal backpressure: the caller must never push when full nor pop when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CW-1:0]    occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop_i) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign occ_o  = cnt_q;
    assign head_o = mem_q[rd_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle synchronous imem; optional debug read port under IMEM_FETCH_DBG_EN.
// Latency: response bypasses to if_* the cycle after issue; redirect target is presented two cycles later.
// Backpressure: if_ready low parks responses in the 2-entry skid buffer; issue stops when credits run out.
module imem_fetch_ctrl #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_dout,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_pc,
    output logic [DATA_WIDTH-1:0] if_instr
`ifdef IMEM_FETCH_DBG_EN
    ,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata
`endif
);

    import imem_pkg::*;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            req_q, req_d;
    logic [1:0]      occ;
    logic [2:0]      inflight;
    logic            deq, issue, push, pop, stall_dbg;
    fetch_entry_t    head, rsp_ent, out_ent;
    logic [ADDR_WIDTH-1:0] fetch_waddr;

    assign fetch_waddr = ADDR_WIDTH'(pc_to_waddr(fetch_pc_q));

`ifdef IMEM_FETCH_DBG_EN
    logic dbg_rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbg_rvalid_q <= 1'b0;
        else        dbg_rvalid_q <= dbg_req;
    end

    assign stall_dbg  = dbg_req;
    assign dbg_gnt    = dbg_req;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = imem_dout;
    assign imem_addr  = dbg_req ? dbg_addr : fetch_waddr;
`else
    assign stall_dbg  = 1'b0;
    assign imem_addr  = fetch_waddr;
`endif

    assign rsp_ent.pc    = rsp_pc_q;
    assign rsp_ent.instr = INSTR_W'(imem_dout);

    // Buffered entries are older than the response now on imem_dout, so the head has priority.
    always_comb begin
        out_ent = '0;
        if (occ != 2'd0) out_ent = head;
        else if (req_q)  out_ent = rsp_ent;
    end

    assign if_valid = (occ != 2'd0) | req_q;
    assign if_pc    = out_ent.pc;
    assign if_instr = DATA_WIDTH'(out_ent.instr);
    assign deq      = if_valid & if_ready;
    assign push     = req_q & ~((occ == 2'd0) & deq);
    assign pop      = deq & (occ != 2'd0);

    // Credits: buffered + in-flight after this cycle's dequeue must leave room for one more.
    assign inflight = {1'b0, occ} + {2'b00, req_q};
    assign issue    = ~redirect_valid & ~stall_dbg & (inflight < (deq ? 3'd3 : 3'd2));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        req_d      = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
        end else if (issue) begin
            req_d      = 1'b1;
            rsp_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= '0;
            req_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            req_q      <= req_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push & ~redirect_valid),
        .entry_i (rsp_ent),
        .pop_i   (pop & ~redirect_valid),
        .flush_i (redirect_valid),
        .occ_o   (occ),
        .head_o  (head)
    );

endmodule
